// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, mode encoding and gradient helpers for the Sobel stream
package sobel_pkg;

  // Widest pixel the helpers handle; narrower pixels are zero-extended into it.
  localparam int PIX_W_MAX   = 16;
  // Gradient headroom above the pixel width: 4*(2^P-1) needs P+2 bits plus sign.
  localparam int GRAD_EXTRA  = 3;
  localparam int GRAD_W_MAX  = PIX_W_MAX + GRAD_EXTRA;

  // Output mode encoding.
  localparam logic MODE_MAG = 1'b0;
  localparam logic MODE_BIN = 1'b1;

  // Window packed as index i*3+j, i = row (0 oldest), j = column (0 oldest).
  typedef logic [8:0][PIX_W_MAX-1:0]     win_t;
  typedef logic signed [GRAD_W_MAX-1:0]  grad_t;
  typedef logic [GRAD_W_MAX-1:0]         mag_t;

  function automatic grad_t tap(input win_t w, input logic [3:0] k);
    return $signed({{GRAD_EXTRA{1'b0}}, w[k]});
  endfunction

  // Horizontal gradient: right column minus left column, centre row doubled.
  function automatic grad_t sobel_gx(input win_t w);
    return (tap(w, 4'd2) + (tap(w, 4'd5) <<< 1) + tap(w, 4'd8))
         - (tap(w, 4'd0) + (tap(w, 4'd3) <<< 1) + tap(w, 4'd6));
  endfunction

  // Vertical gradient: bottom row minus top row, centre column doubled.
  function automatic grad_t sobel_gy(input win_t w);
    return (tap(w, 4'd6) + (tap(w, 4'd7) <<< 1) + tap(w, 4'd8))
         - (tap(w, 4'd0) + (tap(w, 4'd1) <<< 1) + tap(w, 4'd2));
  endfunction

  function automatic mag_t grad_abs(input grad_t g);
    return g[GRAD_W_MAX-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

  // |Gx| + |Gy|; split out so the pipeline can register Gx/Gy before summing.
  function automatic mag_t sobel_abs_sum(input grad_t gx, input grad_t gy);
    return grad_abs(gx) + grad_abs(gy);
  endfunction

  function automatic mag_t sobel_mag(input win_t w);
    return sobel_abs_sum(sobel_gx(w), sobel_gy(w));
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// rtl/sobel_stream_if.sv - upstream/downstream FIFO handshake bundle for sobel_stream
interface sobel_stream_if #(
  parameter int PIX_W = 8
);
  logic             in_rd_en;
  logic             in_empty;
  logic [PIX_W-1:0] in_dout;
  logic             out_wr_en;
  logic             out_full;
  logic [PIX_W-1:0] out_din;
  logic             frame_done;

  // FIFO side: supplies pixels and back-pressure, consumes edge pixels.
  modport master (
    input  in_rd_en, out_wr_en, out_din, frame_done,
    output in_empty, in_dout, out_full
  );

  // Filter side.
  modport slave (
    output in_rd_en, out_wr_en, out_din, frame_done,
    input  in_empty, in_dout, out_full
  );
endinterface

// File: rtl/sobel_stream_window.sv
// rtl/sobel_stream_window.sv - line buffers, 3x3 window and raster counters
module sobel_window #(
  parameter int IMG_WIDTH  = 540,
  parameter int IMG_HEIGHT = 720,
  parameter int PIX_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  accept_i,
  input  logic [PIX_W-1:0]      pix_i,
  // Window as it stands after this accept (i*3+j, row 0 / column 0 oldest).
  output logic [8:0][PIX_W-1:0] window_o,
  output logic                  border_o,
  output logic                  last_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [PIX_W-1:0]        lb0_q [IMG_WIDTH];
  logic [PIX_W-1:0]        lb1_q [IMG_WIDTH];
  logic [8:0][PIX_W-1:0]   win_q, win_d;
  logic                    col_last, row_last;

  assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));

  // The window is not full of current-frame data until two rows and two columns are in.
  assign border_o = (row_q < ROW_W'(2)) || (col_q < COL_W'(2));
  assign last_o   = col_last && row_last;

  // Next window: shift left, new right column is {row r-2, row r-1, row r} at this column.
  always_comb begin
    win_d    = win_q;
    win_d[0] = win_q[1];
    win_d[1] = win_q[2];
    win_d[2] = lb1_q[col_q];
    win_d[3] = win_q[4];
    win_d[4] = win_q[5];
    win_d[5] = lb0_q[col_q];
    win_d[6] = win_q[7];
    win_d[7] = win_q[8];
    win_d[8] = pix_i;
  end

  assign window_o = win_d;

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counters and window register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept_i) begin
        win_q <= win_d;
      end
    end
  end

  // Line buffers: contents stay unreset, the border flag hides stale rows.
  always_ff @(posedge clock) begin
    if (accept_i) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_i;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - FIFO-to-FIFO streaming Sobel edge detector
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 540,
  parameter int IMG_HEIGHT = 720,
  parameter int PIX_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic [PIX_W+2:0]   threshold,
  sobel_stream_if.slave      bus
);

  localparam int               GRAD_W  = PIX_W + GRAD_EXTRA;
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  logic                   advance, accept;
  logic [8:0][PIX_W-1:0]  win;
  win_t                   win_ext;
  logic                   border, last_px;

  logic                   start_q;
  logic                   mode_q;
  logic [GRAD_W-1:0]      thr_q;

  logic                   v1_q, b1_q, l1_q;
  logic signed [GRAD_W-1:0] gx_q, gy_q;

  mag_t                   mag;
  logic [PIX_W-1:0]       pix_d;
  logic                   v2_q, l2_q;
  logic [PIX_W-1:0]       out_q;

  // One global stall: nothing moves while the downstream FIFO is full.
  assign advance      = !bus.out_full;
  assign accept       = !bus.in_empty && advance;
  assign bus.in_rd_en = accept;

  sobel_window #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .PIX_W      (PIX_W)
  ) u_window (
    .clock    (clock),
    .reset    (reset),
    .accept_i (accept),
    .pix_i    (bus.in_dout),
    .window_o (win),
    .border_o (border),
    .last_o   (last_px)
  );

  for (genvar k = 0; k < 9; k++) begin : g_ext
    assign win_ext[k] = PIX_W_MAX'(win[k]);
  end

  // Frame-start tracking and per-frame latch of mode/threshold on pixel (0,0).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q <= 1'b1;
      mode_q  <= MODE_MAG;
      thr_q   <= '0;
    end else if (accept) begin
      start_q <= last_px;
      if (start_q) begin
        mode_q <= mode;
        thr_q  <= threshold;
      end
    end
  end

  // S1: gradients of the freshly updated window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      b1_q <= 1'b0;
      l1_q <= 1'b0;
      gx_q <= '0;
      gy_q <= '0;
    end else if (advance) begin
      v1_q <= accept;
      if (accept) begin
        b1_q <= border;
        l1_q <= last_px;
        gx_q <= GRAD_W'(sobel_gx(win_ext));
        gy_q <= GRAD_W'(sobel_gy(win_ext));
      end
    end
  end

  // S2 combinational: magnitude, then clamp or threshold, with border zeroing.
  always_comb begin
    mag = sobel_abs_sum(grad_t'(gx_q), grad_t'(gy_q));
    pix_d = '0;
    if (!b1_q) begin
      if (mode_q == MODE_BIN) begin
        pix_d = (mag > mag_t'(thr_q)) ? PIX_MAX : '0;
      end else begin
        pix_d = (mag > mag_t'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
      end
    end
  end

  // S2 register: output pixel and its valid/last tags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2_q  <= 1'b0;
      l2_q  <= 1'b0;
      out_q <= '0;
    end else if (advance) begin
      v2_q <= v1_q;
      l2_q <= v1_q && l1_q;
      if (v1_q) begin
        out_q <= pix_d;
      end
    end
  end

  assign bus.out_din    = out_q;
  assign bus.out_wr_en  = v2_q && advance;
  assign bus.frame_done = v2_q && l2_q && advance;

endmodule
